// File: rtl/transform_bin.sv
// transform_bin: sequential BCD-to-binary converter.
// Takes a sign bit plus five packed BCD digits and produces a 16-bit two's-complement word.
// Digits are folded in one per clock, most significant first (acc = acc*10 + digit).
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      conversion request, sampled only while idle
//   BCD_in     five BCD digits, [19:16] ten-thousands ... [3:0] units
//   sign_in    1 = negative, 0 = positive
//   busy       high while digits are being accumulated
//   done       one-cycle pulse; Dec_out and error flags are valid
//   Dec_out    two's-complement result, held until the next done
//   err_digit  a nibble > 9 was seen, held until the next done
//   err_ovf    magnitude out of signed 16-bit range, held until the next done
module transform_bin (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [19:0] BCD_in,
    input  logic        sign_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] Dec_out,
    output logic        err_digit,
    output logic        err_ovf
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e      state_q;
    logic [19:0] bcd_q;
    logic        sign_q;
    logic [16:0] acc_q;
    logic [2:0]  cnt_q;
    logic        dig_err_q;   // sticky invalid-digit flag for the conversion in flight
    logic        busy_q;
    logic        done_q;
    logic [15:0] dec_q;
    logic        err_digit_q;
    logic        err_ovf_q;

    logic [3:0]  digit;
    logic        digit_bad;
    logic [3:0]  digit_val;
    logic [16:0] acc_d;
    logic        dig_err_d;
    logic [15:0] res_dec;
    logic        res_ovf;

    // Digit select: counter 0 picks the MSD.
    always_comb begin
        digit = 4'd0;
        unique case (cnt_q)
            3'd0:    digit = bcd_q[19:16];
            3'd1:    digit = bcd_q[15:12];
            3'd2:    digit = bcd_q[11:8];
            3'd3:    digit = bcd_q[7:4];
            default: digit = bcd_q[3:0];
        endcase
    end

    // Accumulate step and final result, computed from the post-update accumulator so the
    // result is ready on the same edge that enters DONE.
    always_comb begin
        digit_bad = (digit > 4'd9);
        digit_val = digit_bad ? 4'd0 : digit;
        acc_d     = (acc_q << 3) + (acc_q << 1) + {13'd0, digit_val};
        dig_err_d = dig_err_q | digit_bad;

        res_dec = 16'h0000;
        res_ovf = 1'b0;
        if (dig_err_d) begin
            res_dec = 16'h0000;
            res_ovf = 1'b0;
        end else if (!sign_q && (acc_d > 17'd32767)) begin
            res_dec = 16'h7FFF;
            res_ovf = 1'b1;
        end else if (sign_q && (acc_d > 17'd32768)) begin
            res_dec = 16'h8000;
            res_ovf = 1'b1;
        end else if (sign_q) begin
            // -32768 and -0 both fall out of plain 16-bit negation.
            res_dec = 16'h0000 - acc_d[15:0];
        end else begin
            res_dec = acc_d[15:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            bcd_q       <= 20'h00000;
            sign_q      <= 1'b0;
            acc_q       <= 17'd0;
            cnt_q       <= 3'd0;
            dig_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dec_q       <= 16'h0000;
            err_digit_q <= 1'b0;
            err_ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bcd_q     <= BCD_in;
                        sign_q    <= sign_in;
                        acc_q     <= 17'd0;
                        cnt_q     <= 3'd0;
                        dig_err_q <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= StConv;
                    end
                end
                StConv: begin
                    acc_q     <= acc_d;
                    dig_err_q <= dig_err_d;
                    if (cnt_q == 3'd4) begin
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        dec_q       <= res_dec;
                        err_digit_q <= dig_err_d;
                        err_ovf_q   <= res_ovf;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign Dec_out   = dec_q;
    assign err_digit = err_digit_q;
    assign err_ovf   = err_ovf_q;

endmodule
